// File: rtl/bird_motion_ctrl.sv
// bird_motion_ctrl: per-frame vertical physics and game-state FSM for the player sprite.
// Fixed-point position/velocity with gravity, edge-detected flap, terminal velocity and
// ceiling/ground clamping. Optional macro BIRD_CEILING_KILL_EN turns a ceiling clamp
// in FLYING into a transition to DYING.
module bird_motion_ctrl #(
    parameter int unsigned FRAC_BITS   = 4,
    parameter int unsigned X_POS       = 160,
    parameter int unsigned Y_START     = 240,
    parameter int unsigned SIZE        = 4,
    parameter int unsigned GROUND_Y    = 400,
    parameter int unsigned GRAV        = 6,
    parameter int unsigned FLAP_VEL    = 72,
    parameter int unsigned MAX_FALL    = 128,
    parameter logic [7:0]  FLAP_KEY    = 8'h2C,
    parameter logic [7:0]  RESTART_KEY = 8'h15
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic [7:0] keycode,
    input  logic       collision,
    output logic [9:0] BirdX,
    output logic [9:0] BirdY,
    output logic [9:0] BirdS,
    output logic [1:0] state,
    output logic       dead,
    output logic [7:0] flap_count
);

    localparam int unsigned PW = 10 + FRAC_BITS;   // position width (unsigned)
    localparam int unsigned VW = 11 + FRAC_BITS;   // velocity width (signed, +down)
    localparam int unsigned SW = PW + 2;           // signed width for pos + vel

    localparam logic        [PW-1:0] P_START = PW'(Y_START << FRAC_BITS);
    localparam logic        [PW-1:0] P_CEIL  = PW'(SIZE << FRAC_BITS);
    localparam logic        [PW-1:0] P_GND   = PW'((GROUND_Y - SIZE) << FRAC_BITS);
    localparam logic signed [SW-1:0] S_CEIL  = SW'(SIZE << FRAC_BITS);
    localparam logic signed [SW-1:0] S_GND   = SW'((GROUND_Y - SIZE) << FRAC_BITS);
    localparam logic signed [VW-1:0] V_FLAP  = VW'(0) - VW'(FLAP_VEL);
    localparam logic signed [VW-1:0] V_GRAV  = VW'(GRAV);
    localparam logic signed [VW-1:0] V_MAX   = VW'(MAX_FALL);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FLYING   = 2'd1,
        ST_DYING    = 2'd2,
        ST_GROUNDED = 2'd3
    } state_t;

    state_t                 state_q;
    state_t                 state_nxt;
    logic        [PW-1:0]   pos_q;
    logic        [PW-1:0]   pos_nxt;
    logic signed [VW-1:0]   vel_q;
    logic signed [VW-1:0]   vel_nxt;
    logic        [7:0]      prev_key_q;
    logic        [7:0]      flap_cnt_q;
    logic        [7:0]      flap_cnt_nxt;
    logic                   dead_q;
    logic                   dead_nxt;
    logic        [9:0]      bird_x_q;
    logic        [9:0]      bird_s_q;

    logic                   flap_evt;
    logic                   restart_evt;
    logic                   use_flap;
    logic signed [VW-1:0]   v_inc;
    logic signed [VW-1:0]   v_grav;
    logic signed [VW-1:0]   v_step;
    logic signed [SW-1:0]   pos_sum;
    logic                   hit_ceil;
    logic                   hit_gnd;

    // Key press edges and the candidate physics step for this frame.
    always_comb begin
        flap_evt    = (keycode == FLAP_KEY) && (prev_key_q != FLAP_KEY);
        restart_evt = (keycode == RESTART_KEY) && (prev_key_q != RESTART_KEY);
        // Collision outranks a flap in FLYING; DYING and GROUNDED never flap.
        use_flap    = flap_evt && ((state_q == ST_IDLE) ||
                                   ((state_q == ST_FLYING) && !collision));
        v_inc       = vel_q + V_GRAV;
        v_grav      = (v_inc > V_MAX) ? V_MAX : v_inc;
        v_step      = use_flap ? V_FLAP : v_grav;
        pos_sum     = $signed({2'b00, pos_q}) + $signed({{(SW-VW){v_step[VW-1]}}, v_step});
        hit_ceil    = (pos_sum < S_CEIL);
        hit_gnd     = (pos_sum >= S_GND);
    end

    // Game-state register.
    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next-state logic; ground contact wins over collision and ceiling.
    always_comb begin
        state_nxt = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (flap_evt) state_nxt = ST_FLYING;
            end
            ST_FLYING: begin
                if (hit_gnd) begin
                    state_nxt = ST_GROUNDED;
                end else if (collision) begin
                    state_nxt = ST_DYING;
                end
`ifdef BIRD_CEILING_KILL_EN
                else if (hit_ceil) begin
                    state_nxt = ST_DYING;
                end
`endif
            end
            ST_DYING: begin
                if (hit_gnd) state_nxt = ST_GROUNDED;
            end
            ST_GROUNDED: begin
                if (restart_evt) state_nxt = ST_IDLE;
            end
        endcase
    end

    // Next values of position, velocity, flap counter and dead flag.
    always_comb begin
        pos_nxt      = pos_q;
        vel_nxt      = vel_q;
        flap_cnt_nxt = flap_cnt_q;
        dead_nxt     = (state_nxt == ST_DYING) || (state_nxt == ST_GROUNDED);
        unique case (state_q)
            ST_IDLE: begin
                if (flap_evt) begin
                    vel_nxt      = V_FLAP;
                    pos_nxt      = PW'(pos_sum);
                    flap_cnt_nxt = 8'd1;
                end
            end
            ST_FLYING, ST_DYING: begin
                vel_nxt = v_step;
                pos_nxt = PW'(pos_sum);
                if (hit_ceil) begin
                    pos_nxt = P_CEIL;
                    vel_nxt = '0;
                end else if (hit_gnd) begin
                    pos_nxt = P_GND;
                    vel_nxt = '0;
                end
                if (use_flap && (flap_cnt_q != 8'hFF)) begin
                    flap_cnt_nxt = flap_cnt_q + 8'd1;
                end
            end
            ST_GROUNDED: begin
                if (restart_evt) begin
                    pos_nxt      = P_START;
                    vel_nxt      = '0;
                    flap_cnt_nxt = 8'd0;
                end
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            pos_q      <= P_START;
            vel_q      <= '0;
            prev_key_q <= 8'd0;
            flap_cnt_q <= 8'd0;
            dead_q     <= 1'b0;
        end else begin
            pos_q      <= pos_nxt;
            vel_q      <= vel_nxt;
            prev_key_q <= keycode;
            flap_cnt_q <= flap_cnt_nxt;
            dead_q     <= dead_nxt;
        end
    end

    // Constant sprite geometry, reloaded every frame.
    always_ff @(posedge frame_clk) begin
        bird_x_q <= 10'(X_POS);
        bird_s_q <= 10'(SIZE);
    end

    assign BirdX      = bird_x_q;
    assign BirdS      = bird_s_q;
    assign BirdY      = pos_q[PW-1:FRAC_BITS];
    assign state      = state_q;
    assign dead       = dead_q;
    assign flap_count = flap_cnt_q;

endmodule

// File: tb/tb_bird_motion_ctrl.sv
// Self-checking bench for bird_motion_ctrl: directed phases plus randomized play,
// every frame compared against a behavioural model in 1/16-pixel integer units.
module tb_bird_motion_ctrl;

    localparam int ONE    = 16;          // 1 px in fixed-point units
    localparam int CEIL   = 4 * ONE;
    localparam int GROUND = 396 * ONE;
    localparam int START  = 240 * ONE;

    logic       frame_clk = 1'b0;
    logic       Reset     = 1'b1;
    logic [7:0] keycode   = 8'h00;
    logic       collision = 1'b0;
    logic [9:0] BirdX;
    logic [9:0] BirdY;
    logic [9:0] BirdS;
    logic [1:0] state;
    logic       dead;
    logic [7:0] flap_count;

    int n_total = 0;
    int n_bad   = 0;

    // Model state.
    int m_pos   = START;
    int m_vel   = 0;
    int m_state = 0;
    int m_cnt   = 0;
    int m_prev  = 0;

    bird_motion_ctrl dut (
        .frame_clk  (frame_clk),
        .Reset      (Reset),
        .keycode    (keycode),
        .collision  (collision),
        .BirdX      (BirdX),
        .BirdY      (BirdY),
        .BirdS      (BirdS),
        .state      (state),
        .dead       (dead),
        .flap_count (flap_count)
    );

    always #5 frame_clk = ~frame_clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_total++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One frame of game rules on the model.
    task automatic model_step(input bit rst, input int key, input bit col);
        bit fe;
        bit re;
        bit flap_ok;
        int v;
        int p;
        int nxt;
        if (rst) begin
            m_state = 0; m_pos = START; m_vel = 0; m_cnt = 0; m_prev = 0;
            return;
        end
        fe = (key == 'h2C) && (m_prev != 'h2C);
        re = (key == 'h15) && (m_prev != 'h15);
        case (m_state)
            0: if (fe) begin
                m_vel = -72; m_pos = m_pos - 72; m_cnt = 1; m_state = 1;
            end
            1, 2: begin
                flap_ok = (m_state == 1) && fe && !col;
                v   = flap_ok ? -72 : ((m_vel + 6 > 128) ? 128 : m_vel + 6);
                p   = m_pos + v;
                nxt = (m_state == 1 && col) ? 2 : m_state;
                if (p < CEIL) begin
                    p = CEIL; v = 0;
`ifdef BIRD_CEILING_KILL_EN
                    if (m_state == 1) nxt = 2;
`endif
                end else if (p >= GROUND) begin
                    p = GROUND; v = 0; nxt = 3;
                end
                if (flap_ok && m_cnt < 255) m_cnt++;
                m_pos = p; m_vel = v; m_state = nxt;
            end
            default: if (re) begin
                m_state = 0; m_pos = START; m_vel = 0; m_cnt = 0;
            end
        endcase
        m_prev = key;
    endtask

    // Apply inputs for one frame, advance model, compare after the edge.
    task automatic frame(input bit rst, input int key, input bit col);
        Reset     = rst;
        keycode   = 8'(key);
        collision = col;
        @(posedge frame_clk);
        model_step(rst, key, col);
        #1;
        check_eq("BirdY", int'(BirdY), m_pos / ONE);
        check_eq("state", int'(state), m_state);
        check_eq("dead", int'(dead), (m_state >= 2) ? 1 : 0);
        check_eq("flap_count", int'(flap_count), m_cnt);
        check_eq("BirdX", int'(BirdX), 160);
        check_eq("BirdS", int'(BirdS), 4);
    endtask

    initial begin
        int k;
        int hold;
        // Reset, then idle frames keep the bird at its start height.
        frame(1, 0, 0);
        frame(1, 0, 0);
        for (int i = 0; i < 5; i++) frame(0, 0, 0);
        check_eq("idle_y", int'(BirdY), 240);

        // Held flap key gives exactly one flap.
        frame(0, 'h2C, 0);
        check_eq("first_flap_y", int'(BirdY), 235);
        for (int i = 0; i < 9; i++) frame(0, 'h2C, 0);
        check_eq("held_count", int'(flap_count), 1);

        // Free fall to the ground.
        for (int i = 0; i < 200; i++) frame(0, 0, 0);
        check_eq("landed_y", int'(BirdY), 396);
        check_eq("landed_state", int'(state), 3);

        // Flap ignored in GROUNDED, restart returns to IDLE.
        frame(0, 'h2C, 0);
        frame(0, 0, 0);
        frame(0, 'h15, 0);
        check_eq("restart_state", int'(state), 0);

        // Collision coincident with a flap press, then ignored flaps while dying.
        frame(0, 'h2C, 0);
        frame(0, 0, 0);
        frame(0, 0, 0);
        frame(0, 'h2C, 1);
        check_eq("collide_state", int'(state), 2);
        for (int i = 0; i < 200; i++) frame(0, (i % 2 == 0) ? 'h2C : 0, 0);
        check_eq("dying_landed", int'(state), 3);

        // Rapid flapping into the ceiling; counter saturates.
        frame(0, 'h15, 0);
        for (int i = 0; i < 600; i++) frame(0, (i % 2 == 0) ? 'h2C : 0, 0);

        // Randomized play with occasional collisions and mid-game resets.
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 4))
                0, 1: k = 0;
                2:    k = 'h2C;
                3:    k = 'h15;
                default: k = int'($urandom_range(0, 255));
            endcase
            hold = $urandom_range(1, 3);
            for (int j = 0; j < hold; j++)
                frame($urandom_range(0, 299) == 0, k, $urandom_range(0, 39) == 0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
